digi_display_sched: RTL and testbench

Round-robin scheduler that shares one `hex2decdigi_6bit` converter among `NCH` display channels (e.g. seconds, minutes, hours). It latches per-channel 6-bit values and issues at most one value per cycle to the shared converter. It tracks each conversion through the converter's fixed pipeline latency and writes the returned digit pair into the matching channel's segment register. It also performs a periodic forced refresh of all channels.

---
 rtl/digi_display_sched_if.sv | 24 ++
 rtl/digi_display_sched.sv | 107 ++++++++++
 tb/tb_digi_display_sched.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/digi_display_sched_if.sv
// Request, converter and display signals of digi_display_sched.
// slave is the scheduler side, master is the driving environment.
interface digi_display_sched_if #(
    parameter int unsigned NCH = 3
);
    logic [NCH-1:0]    req_valid;
    logic [6*NCH-1:0]  req_value;
    logic [5:0]        conv_hex;
    logic [6:0]        conv_digi_0;
    logic [6:0]        conv_digi_1;
    logic [14*NCH-1:0] seg_out;
    logic [NCH-1:0]    seg_update;
    logic              busy;

    modport master (
        output req_valid, req_value, conv_digi_0, conv_digi_1,
        input  conv_hex, seg_out, seg_update, busy
    );

    modport slave (
        input  req_valid, req_value, conv_digi_0, conv_digi_1,
        output conv_hex, seg_out, seg_update, busy
    );
endinterface

// File: rtl/digi_display_sched.sv
// Round-robin sharing of one hex-to-decimal-digit converter among NCH display
// channels, with a tag delay line matching converter latency and periodic refresh.
module digi_display_sched #(
    parameter int unsigned NCH     = 3,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned REFRESH = 1024
) (
    input logic                 clock,
    input logic                 rst_n,
    digi_display_sched_if.slave bus
);
    localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [5:0]        shadow [NCH];
    logic [NCH-1:0]    pending;
    logic [NCH-1:0]    pending_nx;
    logic [NCH-1:0]    issue_mask;
    logic [PW-1:0]     ptr;
    logic [LATENCY:0]  tag_vld;
    logic [PW-1:0]     tag_ch [LATENCY+1];
    logic [5:0]        conv_hex_q;
    logic [14*NCH-1:0] seg_out_q;
    logic [NCH-1:0]    seg_update_q;
    logic              wrap;
    logic              sel_found;
    logic [PW-1:0]     sel;

    // First pending channel at or after ptr, circular order.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        sel_found = 1'b0;
        sel       = '0;
        for (int unsigned off = 0; off < NCH; off++) begin
            idx = (32'(ptr) + off) % NCH;
            if (!sel_found && pending[idx]) begin
                sel_found = 1'b1;
                sel       = PW'(idx);
            end
        end
    end

    always_comb begin
        issue_mask = '0;
        if (sel_found) issue_mask[sel] = 1'b1;
        // New requests and refresh wrap override the clear of the channel being issued.
        pending_nx = (pending & ~issue_mask) | bus.req_valid | {NCH{wrap}};
    end

    generate
        if (REFRESH == 0) begin : g_no_refresh
            assign wrap = 1'b0;
        end else begin : g_refresh
            localparam int unsigned CW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
            logic [CW-1:0] cnt;

            assign wrap = (cnt == CW'(REFRESH - 1));

            always_ff @(posedge clock or negedge rst_n) begin
                if (!rst_n) cnt <= '0;
                else        cnt <= wrap ? '0 : cnt + CW'(1);
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pending      <= '0;
            ptr          <= '0;
            tag_vld      <= '0;
            conv_hex_q   <= '0;
            seg_out_q    <= '0;
            seg_update_q <= '0;
            for (int unsigned i = 0; i < NCH; i++) shadow[i] <= '0;
            for (int unsigned s = 0; s <= LATENCY; s++) tag_ch[s] <= '0;
        end else begin
            pending <= pending_nx;
            for (int unsigned i = 0; i < NCH; i++) begin
                if (bus.req_valid[i]) shadow[i] <= bus.req_value[6*i +: 6];
            end

            if (sel_found) begin
                conv_hex_q <= shadow[sel];
                ptr        <= (sel == PW'(NCH - 1)) ? '0 : sel + PW'(1);
            end

            tag_vld[0] <= sel_found;
            tag_ch[0]  <= sel;
            for (int unsigned s = 1; s <= LATENCY; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_ch[s]  <= tag_ch[s-1];
            end

            // The tag leaving the delay line names the channel whose digits are on the converter now.
            for (int unsigned i = 0; i < NCH; i++) begin
                seg_update_q[i] <= tag_vld[LATENCY] && (tag_ch[LATENCY] == PW'(i));
                if (tag_vld[LATENCY] && (tag_ch[LATENCY] == PW'(i)))
                    seg_out_q[14*i +: 14] <= {bus.conv_digi_1, bus.conv_digi_0};
            end
        end
    end

    assign bus.conv_hex   = conv_hex_q;
    assign bus.seg_out    = seg_out_q;
    assign bus.seg_update = seg_update_q;
    assign bus.busy       = (|pending) || (|tag_vld);
endmodule

// File: tb/tb_digi_display_sched.sv
// Bench for digi_display_sched: two instances (refresh off / every 16 cycles) against a
// transaction-level model with a queue of conversions due on a given edge.
module tb_digi_display_sched;
    localparam int unsigned NCH     = 3;
    localparam int unsigned LATENCY = 2;
    localparam int unsigned REF1    = 16;
    localparam int unsigned VW      = 6 * NCH;

    logic           clock     = 1'b0;
    logic           rst_n     = 1'b0;
    logic [NCH-1:0] req_valid = '0;
    logic [VW-1:0]  req_value = '0;
    logic [5:0]     cpipe0 [LATENCY] = '{default: '0};
    logic [5:0]     cpipe1 [LATENCY] = '{default: '0};

    int n_checks = 0;
    int n_errors = 0;
    int ch2_lat;
    int unsigned multi_val [3] = '{5, 59, 63};

    always #5 clock = ~clock;

    digi_display_sched_if #(.NCH(NCH)) bus0 ();
    digi_display_sched_if #(.NCH(NCH)) bus1 ();

    digi_display_sched #(.NCH(NCH), .LATENCY(LATENCY), .REFRESH(0)) dut0 (
        .clock(clock), .rst_n(rst_n), .bus(bus0));
    digi_display_sched #(.NCH(NCH), .LATENCY(LATENCY), .REFRESH(REF1)) dut1 (
        .clock(clock), .rst_n(rst_n), .bus(bus1));

    // Segment order {g,a,b,c,d,e,f}
    function automatic logic [6:0] seg_code(input int unsigned d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0011000;
            2: return 7'b1110110;
            3: return 7'b1111100;
            4: return 7'b1011001;
            5: return 7'b1101101;
            6: return 7'b1101111;
            7: return 7'b0111000;
            8: return 7'b1111111;
            9: return 7'b1111101;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [13:0] digits(input int unsigned v);
        return {seg_code(v / 10), seg_code(v % 10)};
    endfunction

    // Converter stand-in: LATENCY edges from hex sampled to digits valid.
    always @(posedge clock) begin
        cpipe0[0] <= bus0.conv_hex;
        cpipe1[0] <= bus1.conv_hex;
        for (int s = 1; s < LATENCY; s++) begin
            cpipe0[s] <= cpipe0[s-1];
            cpipe1[s] <= cpipe1[s-1];
        end
    end

    assign bus0.req_valid   = req_valid;
    assign bus0.req_value   = req_value;
    assign bus1.req_valid   = req_valid;
    assign bus1.req_value   = req_value;
    assign bus0.conv_digi_1 = seg_code(32'(cpipe0[LATENCY-1]) / 10);
    assign bus0.conv_digi_0 = seg_code(32'(cpipe0[LATENCY-1]) % 10);
    assign bus1.conv_digi_1 = seg_code(32'(cpipe1[LATENCY-1]) / 10);
    assign bus1.conv_digi_0 = seg_code(32'(cpipe1[LATENCY-1]) % 10);

    typedef struct {
        int          m;
        int unsigned due;
        int unsigned ch;
        int unsigned val;
    } conv_t;

    conv_t             infl [$];
    int unsigned       m_shadow [2][NCH];
    bit                m_pend   [2][NCH];
    int unsigned       m_ptr    [2];
    int unsigned       m_edge   [2];
    logic [14*NCH-1:0] e_seg    [2];
    logic [NCH-1:0]    e_upd    [2];
    logic [5:0]        e_hex    [2];
    int unsigned       upd_cnt  [2][NCH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        infl.delete();
        for (int m = 0; m < 2; m++) begin
            m_ptr[m]  = 0;
            m_edge[m] = 0;
            e_seg[m]  = '0;
            e_upd[m]  = '0;
            e_hex[m]  = '0;
            for (int i = 0; i < NCH; i++) begin
                m_shadow[m][i] = 0;
                m_pend[m][i]   = 1'b0;
            end
        end
    endtask

    // Expected effect of the coming clock edge, using the inputs currently driven.
    task automatic model_edge(input int m);
        int unsigned e, k, period, idx;
        bit          found;
        conv_t       c;
        m_edge[m]++;
        e        = m_edge[m];
        period   = (m == 0) ? 0 : REF1;
        e_upd[m] = '0;
        for (int i = infl.size() - 1; i >= 0; i--) begin
            if (infl[i].m == m && infl[i].due == e) begin
                e_upd[m][infl[i].ch]          = 1'b1;
                e_seg[m][14*infl[i].ch +: 14] = digits(infl[i].val);
                infl.delete(i);
            end
        end
        found = 1'b0;
        k     = 0;
        for (int unsigned off = 0; off < NCH; off++) begin
            idx = (m_ptr[m] + off) % NCH;
            if (!found && m_pend[m][idx]) begin
                found = 1'b1;
                k     = idx;
            end
        end
        if (found) begin
            e_hex[m]     = 6'(m_shadow[m][k]);
            m_pend[m][k] = 1'b0;
            c.m   = m;
            c.due = e + LATENCY + 1;
            c.ch  = k;
            c.val = m_shadow[m][k];
            infl.push_back(c);
            m_ptr[m] = (k + 1) % NCH;
        end
        if (period != 0 && (e % period) == 0)
            for (int i = 0; i < NCH; i++) m_pend[m][i] = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (req_valid[i]) begin
                m_shadow[m][i] = 32'(req_value[6*i +: 6]);
                m_pend[m][i]   = 1'b1;
            end
        end
    endtask

    function automatic logic model_busy(input int m);
        logic b;
        b = 1'b0;
        for (int i = 0; i < NCH; i++) if (m_pend[m][i]) b = 1'b1;
        foreach (infl[i]) if (infl[i].m == m) b = 1'b1;
        return b;
    endfunction

    function automatic int unsigned total(input int m);
        int unsigned t;
        t = 0;
        for (int i = 0; i < NCH; i++) t += upd_cnt[m][i];
        return t;
    endfunction

    task automatic clear_counts();
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < NCH; i++) upd_cnt[m][i] = 0;
    endtask

    task automatic cycle();
        if (rst_n) begin
            model_edge(0);
            model_edge(1);
        end
        @(posedge clock);
        #1;
        check("d0.seg_out",    64'(bus0.seg_out),    64'(e_seg[0]));
        check("d0.seg_update", 64'(bus0.seg_update), 64'(e_upd[0]));
        check("d0.conv_hex",   64'(bus0.conv_hex),   64'(e_hex[0]));
        check("d0.busy",       64'(bus0.busy),       64'(model_busy(0)));
        check("d1.seg_out",    64'(bus1.seg_out),    64'(e_seg[1]));
        check("d1.seg_update", 64'(bus1.seg_update), 64'(e_upd[1]));
        check("d1.conv_hex",   64'(bus1.conv_hex),   64'(e_hex[1]));
        check("d1.busy",       64'(bus1.busy),       64'(model_busy(1)));
        for (int i = 0; i < NCH; i++) begin
            upd_cnt[0][i] += 32'(bus0.seg_update[i]);
            upd_cnt[1][i] += 32'(bus1.seg_update[i]);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        model_reset();
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        clear_counts();

        // Reset held with random inputs
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            req_valid = NCH'($urandom);
            req_value = VW'($urandom);
            cycle();
        end
        req_valid = '0;
        rst_n     = 1'b1;
        clear_counts();
        repeat (20) cycle();
        check("idle.no_updates", 64'(total(0)), 64'(0));

        // Single request: ch0 = 42
        req_valid = 3'b001;
        req_value = '0;
        req_value[5:0] = 6'd42;
        cycle();
        req_valid = '0;
        cycle();
        check("single.conv_hex", 64'(bus0.conv_hex), 64'(42));
        cycle();
        cycle();
        check("single.early_update", 64'(bus0.seg_update), 64'(0));
        cycle();
        check("single.seg_update", 64'(bus0.seg_update), 64'(3'b001));
        check("single.seg_out", 64'(bus0.seg_out[13:0]), 64'(14'b1011001_1110110));
        cycle();
        check("single.pulse_end", 64'(bus0.seg_update), 64'(0));

        // Three simultaneous requests from a fresh reset (ptr = 0)
        pulse_reset();
        req_valid = '1;
        req_value = {6'd63, 6'd59, 6'd5};
        cycle();
        req_valid = '0;
        for (int s = 0; s < 3; s++) begin
            cycle();
            check("multi.issue", 64'(bus0.conv_hex), 64'(multi_val[s]));
        end
        for (int s = 0; s < 3; s++) begin
            cycle();
            check("multi.update", 64'(bus0.seg_update), 64'(1) << s);
        end
        check("multi.seg_out", 64'(bus0.seg_out),
              64'({14'b1101111_1111100, 14'b1101101_1111101, 14'b0111111_1101101}));

        // Fairness and overwrite: ch0 held, ch2 once, ch1 twice
        clear_counts();
        ch2_lat = -1;
        for (int c = 0; c < 14; c++) begin
            req_valid = 3'b001;
            req_value = '0;
            if (c == 0) begin
                req_valid[2]     = 1'b1;
                req_value[17:12] = 6'd7;
                req_valid[1]     = 1'b1;
                req_value[11:6]  = 6'd10;
            end
            if (c == 1) begin
                req_valid[1]    = 1'b1;
                req_value[11:6] = 6'd11;
            end
            cycle();
            if (ch2_lat < 0 && bus0.seg_update[2]) ch2_lat = c;
        end
        req_valid = '0;
        repeat (8) cycle();
        check("fair.ch2_in_time", 64'(ch2_lat >= 0 && ch2_lat <= int'(NCH + LATENCY + 1)), 64'(1));
        check("fair.ch1_seg", 64'(bus0.seg_out[27:14]), 64'(14'b0011000_0011000));
        check("fair.ch1_updates_le2", 64'(upd_cnt[0][1] >= 1 && upd_cnt[0][1] <= 2), 64'(1));
        check("fair.ch2_seg", 64'(bus0.seg_out[41:28]), 64'(14'b0111111_0111000));

        // Refresh: values stay, three pulses per 16 cycles on the refreshing instance
        repeat (20) cycle();
        clear_counts();
        repeat (48) cycle();
        check("refresh.d1_pulses", 64'(total(1)), 64'(9));
        for (int i = 0; i < NCH; i++)
            check("refresh.d1_per_channel", 64'(upd_cnt[1][i]), 64'(3));
        check("refresh.d0_pulses", 64'(total(0)), 64'(0));
        check("refresh.d1_seg_out", 64'(bus1.seg_out), 64'({digits(7), digits(11), digits(0)}));

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            req_valid = ($urandom_range(0, 2) == 0) ? NCH'($urandom) : '0;
            req_value = VW'($urandom);
            cycle();
        end
        req_valid = '0;
        repeat (10) cycle();

        // Reset one edge after an issue
        req_valid = 3'b010;
        req_value = '0;
        req_value[11:6] = 6'd33;
        cycle();
        req_valid = '0;
        cycle();
        cycle();
        pulse_reset();
        clear_counts();
        repeat (8) cycle();
        check("midrst.updates", 64'(total(0) + total(1)), 64'(0));
        check("midrst.seg_out", 64'(bus0.seg_out), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
